// File: rtl/syn_ram_pkg.sv
// Shared constants, state encoding and lane-merge helper for syn_dual_port_ram_be.
// Latency: n/a (package). Backpressure: n/a.
// Provides the lane-merge function used by both the write path and the read bypass.
package syn_ram_pkg;

  localparam int DEF_RAM_WIDTH  = 8;
  localparam int DEF_RAM_DEPTH  = 16;
  localparam int DEF_ADDR_SIZE  = 4;
  localparam int DEF_LANE_WIDTH = 8;

  // Merge helper works on a fixed wide word; callers cast in and out.
  localparam int MERGE_W  = 256;
  localparam int MERGE_AW = 8;

  typedef logic [MERGE_W-1:0] merge_word_t;

  typedef enum logic {ST_CLEAR, ST_IDLE} ram_state_t;

  function automatic merge_word_t lane_merge(input merge_word_t old_word,
                                             input merge_word_t new_word,
                                             input merge_word_t be,
                                             input int          lane_width);
    merge_word_t merged;
    merged = old_word;
    for (int i = 0; i < MERGE_W; i++) begin
      if (be[MERGE_AW'(i / lane_width)]) merged[i] = new_word[i];
    end
    return merged;
  endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer: walks clr_addr over the whole array, one word per cycle.
// Latency: busy drops RAM_DEPTH cycles after reset is released.
// Backpressure: none; the top ignores user requests while busy is high.
module ram_clear_seq
  import syn_ram_pkg::*;
#(
  parameter int RAM_DEPTH = DEF_RAM_DEPTH,
  parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic                 clr_we,
  output logic [ADDR_SIZE-1:0] clr_addr,
  output logic                 busy
);

  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(RAM_DEPTH - 1);

  ram_state_t           state, state_nxt;
  logic [ADDR_SIZE-1:0] clr_ptr, clr_ptr_nxt;
  logic                 busy_nxt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
      busy    <= 1'b1;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
      busy    <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    busy_nxt    = busy;
    clr_we      = 1'b0;
    case (state)
      ST_CLEAR: begin
        // Memory must stay untouched while reset is held.
        clr_we      = !reset;
        clr_ptr_nxt = clr_ptr + ADDR_SIZE'(1);
        if (clr_ptr == LAST_ADDR) begin
          state_nxt   = ST_IDLE;
          clr_ptr_nxt = '0;
          busy_nxt    = 1'b0;
        end
      end
      ST_IDLE: busy_nxt = 1'b0;
      default: state_nxt = ST_CLEAR;
    endcase
  end

  assign clr_addr = clr_ptr;

endmodule

// File: rtl/syn_dual_port_ram_be.sv
// Simple dual-port RAM with lane write enables, write-first bypass and self-clear after reset.
// Latency: read data 1 cycle after rd_en (2 cycles with SYN_RAM_OUT_REG_EN defined).
// Backpressure: none; wr_en/rd_en are ignored while busy (clear in progress).
module syn_dual_port_ram_be
  import syn_ram_pkg::*;
#(
  parameter int RAM_WIDTH  = DEF_RAM_WIDTH,
  parameter int RAM_DEPTH  = DEF_RAM_DEPTH,
  parameter int ADDR_SIZE  = DEF_ADDR_SIZE,
  parameter int LANE_WIDTH = DEF_LANE_WIDTH,
  parameter int NUM_LANES  = RAM_WIDTH / LANE_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [ADDR_SIZE-1:0] wr_addr,
  input  logic [NUM_LANES-1:0] wr_be,
  input  logic [RAM_WIDTH-1:0] d_in,
  input  logic                 rd_en,
  input  logic [ADDR_SIZE-1:0] rd_addr,
  output logic [RAM_WIDTH-1:0] d_out,
  output logic                 rd_valid,
  output logic                 busy
);

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

  logic                 clr_we;
  logic [ADDR_SIZE-1:0] clr_addr;
  logic                 wr_in_range, rd_in_range;
  logic                 user_we, rd_req;
  logic [RAM_WIDTH-1:0] wr_word, rd_word;

  ram_clear_seq #(
    .RAM_DEPTH(RAM_DEPTH),
    .ADDR_SIZE(ADDR_SIZE)
  ) u_clear_seq (
    .clock   (clock),
    .reset   (reset),
    .clr_we  (clr_we),
    .clr_addr(clr_addr),
    .busy    (busy)
  );

  assign wr_in_range = 32'(wr_addr) < RAM_DEPTH;
  assign rd_in_range = 32'(rd_addr) < RAM_DEPTH;
  assign user_we     = wr_en && !busy && wr_in_range;
  assign rd_req      = rd_en && !busy;

  always_comb begin
    wr_word = '0;
    if (wr_in_range)
      wr_word = RAM_WIDTH'(lane_merge(merge_word_t'(mem[wr_addr]), merge_word_t'(d_in),
                                      merge_word_t'(wr_be), LANE_WIDTH));
  end

  // Write-first: a same-address write in this cycle is merged into the read word.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      if (user_we && wr_addr == rd_addr)
        rd_word = wr_word;
      else
        rd_word = mem[rd_addr];
    end
  end

  always_ff @(posedge clock) begin
    if (clr_we)
      mem[clr_addr] <= '0;
    else if (user_we)
      mem[wr_addr] <= wr_word;
  end

`ifdef SYN_RAM_OUT_REG_EN
  logic [RAM_WIDTH-1:0] d_stage;
  logic                 v_stage;

  always_ff @(posedge clock) begin
    if (reset) begin
      d_stage  <= '0;
      v_stage  <= 1'b0;
      d_out    <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (rd_req) d_stage <= rd_word;
      v_stage  <= rd_req;
      if (v_stage) d_out <= d_stage;
      rd_valid <= v_stage;
    end
  end
`else
  always_ff @(posedge clock) begin
    if (reset) begin
      d_out    <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (rd_req) d_out <= rd_word;
      rd_valid <= rd_req;
    end
  end
`endif

endmodule

// File: doc/syn_dual_port_ram_be.md
Name: syn_dual_port_ram_be

Overview:
- Parametrised synchronous simple dual-port RAM with one write port and one read port.
- Generalises the fixed 16x8 dual-port RAM in width and depth, and adds per-lane byte enables, a defined read-during-write rule and a read-valid strobe.
- A hardware clear sequencer zeroes the whole array after reset.
- Used as the generic buffer memory beneath FIFOs and line buffers in the sequential library.

Parameters:
- RAM_WIDTH, 8, data word width in bits; must be a multiple of LANE_WIDTH.
- RAM_DEPTH, 16, number of words; need not be a power of two.
- ADDR_SIZE, 4, address width in bits; must satisfy 2**ADDR_SIZE >= RAM_DEPTH.
- LANE_WIDTH, 8, bits per byte-enable lane.
- NUM_LANES, RAM_WIDTH/LANE_WIDTH, derived; never overridden.

Ports:
- clock  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_SIZE  write address.
- wr_be  in  NUM_LANES  lane write enables; bit i covers d_in[i*LANE_WIDTH +: LANE_WIDTH].
- d_in  in  RAM_WIDTH  write data.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_SIZE  read address.
- d_out  out  RAM_WIDTH  registered read data.
- rd_valid  out  1  d_out holds fresh read data this cycle.
- busy  out  1  clear sequence in progress; requests are ignored.

Behaviour:
- Interface: one clock, clock; reset is synchronous and active-high, with no asynchronous term.
- Reset, every posedge with reset=1:
  - state <= CLEAR, clr_ptr <= 0.
  - d_out <= 0, rd_valid <= 0, busy <= 1.
  - Memory contents are not touched while reset is held.
- CLEAR state, reset=0:
  - Each cycle writes all-zero to mem[clr_ptr], then clr_ptr increments.
  - The cycle that writes address RAM_DEPTH-1 moves the state to IDLE, and busy <= 0 on the same edge.
  - busy therefore deasserts exactly RAM_DEPTH cycles after the first edge with reset low.
  - wr_en and rd_en are ignored. rd_valid stays 0 and d_out holds 0.
- Reset mid-clear: the sequence restarts at address 0.
- Reset mid-operation: in-flight reads are discarded (rd_valid <= 0).
- IDLE write:
  - At a posedge with wr_en=1, each lane with wr_be[i]=1 is written from d_in; lanes with wr_be[i]=0 keep their old value.
  - wr_be=0 makes the write a no-op.
- IDLE read:
  - At a posedge with rd_en=1, d_out <= mem[rd_addr] and rd_valid <= 1.
  - Latency is 1: data is visible in the cycle after the request edge.
  - With rd_en=0: d_out holds its last value and rd_valid <= 0.
- Read-during-write to the same address in the same cycle is write-first:
  - Enabled lanes return the new d_in.
  - Disabled lanes return the old contents.
- Different addresses on the two ports are fully independent.
- Out-of-range addresses (>= RAM_DEPTH):
  - A write is dropped and memory is unchanged.
  - A read returns 0 with rd_valid=1.
- Back-to-back reads and writes every cycle are supported, with no bubbles.

Optional Feature:
- Macro: SYN_RAM_OUT_REG_EN.
- Defined:
  - An extra output register stage is added; read latency is 2.
  - rd_valid is delayed through a matching stage, so d_out and rd_valid stay aligned.
  - Reset clears both stages.
  - The stage-2 register loads only when the stage-1 valid is set; otherwise it holds.
- Undefined: latency is 1, as described above.

Decomposition:
- Package syn_ram_pkg holds:
  - default RAM_WIDTH, RAM_DEPTH, ADDR_SIZE and LANE_WIDTH constants;
  - state typedef {ST_CLEAR, ST_IDLE};
  - a lane-merge function (old word, new word, be) -> merged word, used by both the write path and the bypass path.
- Sub-module ram_clear_seq holds the state register, clr_ptr counter and busy flag. It outputs clr_we, clr_addr and busy.
- The top level muxes clear writes against user writes.

Test Plan:
- Reset and clear (defaults):
  - Stimulus: pulse reset for 1 cycle, then hold it low.
  - Response: busy=1 for exactly 16 cycles, then 0. Reading addresses 0..15 returns 0x00 each, with rd_valid=1 one cycle after each rd_en edge.
- Basic write/read:
  - Stimulus: write 0x10 to address 7 (be=1); read address 7 on the next cycle.
  - Response: d_out=0x10 with rd_valid=1 one cycle later. rd_valid=0 in the following idle cycle while d_out holds 0x10.
- Byte enables (RAM_WIDTH=16):
  - Stimulus: write 0xAABB to address 3 (be=2'b11), then 0x1122 to address 3 (be=2'b10), then read address 3.
  - Response: d_out=0x11BB.
- Write-first collision:
  - Stimulus: write 0xAA to address 0xF. In the same cycle, write 0xFF to address 0xF (be=1) and read address 0xF.
  - Response: d_out=0xFF on the next cycle.
- Reset mid-operation:
  - Stimulus: write 0xAA to address 0xA; assert reset; while busy=1, drive a write of 0x55 to address 0xA.
  - Response: the busy-time write is ignored; after busy falls, reading address 0xA returns 0x00.
- SYN_RAM_OUT_REG_EN defined:
  - Stimulus: write 0x10 to address 7; issue a single-cycle read of address 7.
  - Response: d_out=0x10 and rd_valid=1 exactly 2 cycles after the request edge, with no earlier valid.
